div_radix_pipe: RTL and testbench
=================================

// Module: div_radix_pipe
// PURPOSE
// - Pipelined signed integer divider: the responder on the FU divider interface (in_valid_i/pea_ready_i in, q_o/r_o/valid_o out).
// - Serves DIV/REM/ABSDIV/ABSREM/CADDDIV in the divider-equipped FU wrapper of each PE.
// - Accepts one operand pair per cycle while pea_ready_i=1; the whole pipeline freezes while pea_ready_i=0.
// PARAMETERS
// - N_BITS      32  operand/result width (from pea_pkg)
// - DIV_STAGES   8  iteration stages; must divide N_BITS; BPS=N_BITS/DIV_STAGES quotient bits per stage
// PORTS
// - clk_i        in   1       clock
// - rst_i        in   1       reset, synchronous, active-high
// - pea_ready_i  in   1       global advance enable; 0 = hold every pipeline register
// - a_i          in   N_BITS  dividend, two's complement
// - b_i          in   N_BITS  divisor, two's complement
// - in_valid_i   in   1       a_i/b_i valid this cycle; sampled only when pea_ready_i=1
// - q_o          out  N_BITS  quotient, registered
// - r_o          out  N_BITS  remainder, registered
// - valid_o      out  1       q_o/r_o valid
// BEHAVIOUR
// - One clock; reset is synchronous and active-high (rst_i); no async path.
// - Reset: all stage valid bits, valid_o, q_o, r_o = 0. Reset mid-operation discards all in-flight ops; valid_o=0 the cycle after rst_i is sampled.
// - Advance rule: every register (data and valid) updates only on a clock edge with pea_ready_i=1; pea_ready_i=0 holds all state, valid_o and outputs held stable.
// - No ready output: the block never back-pressures; upstream holds operands while pea_ready_i=0.
// - Latency: LATENCY = DIV_STAGES+1 advancing edges from acceptance to valid_o=1; throughput 1 op per advancing cycle.
// - Bubbles: in_valid_i=0 inserts a bubble; valid bits shift with the data; ordering strictly FIFO.
// - Input conditioning (combinational, into stage 0): |a|, |b| as N_BITS unsigned; sign_q = a[MSB]^b[MSB]; sign_r = a[MSB].
//   |INT_MIN| = 2^(N_BITS-1) is represented exactly as unsigned.
// - Special flags carried down the pipe:
//   - dz = (b==0)
//   - ovf = (a==INT_MIN && b==-1)
// - Iteration stage k: restoring division, BPS steps.
//   - Per step: partial remainder P (N_BITS+1 bits) = {P,next dividend bit}; if P>=|b| then P-=|b|, qbit=1, else qbit=0.
//   - Stage 0 starts with P=0. Dividend bits are consumed MSB first.
// - Output stage (registered):
//   - q = sign_q ? -Q : Q; r = sign_r ? -R : R
//     (truncate toward zero; remainder takes the dividend's sign).
//   - dz: q = all ones, r = a (original dividend, carried in the pipe).
//   - ovf: q = INT_MIN, r = 0. dz has priority over ovf (cannot both hold).
//   - 0/x: q=0, r=0 regardless of signs.
// - q_o/r_o update only together with valid_o=1; on a bubble they keep their last value.
// STRUCTURE
// - pea_pkg additions:
//   - localparam DIV_STAGES.
//   - typedef div_stage_t: {valid, dz, ovf, sign_q, sign_r, a_orig[N_BITS], div_abs[N_BITS], dvd_rem[N_BITS], p[N_BITS+1], q[N_BITS]}.
// - Sub-module div_stage: combinational BPS-step restoring slice, div_stage_t in -> div_stage_t out.
//   - Instantiated DIV_STAGES times via generate.
//   - Pipeline registers live in div_radix_pipe.
// TESTING
// (N_BITS=32, DIV_STAGES=8, pea_ready_i=1 unless noted)
// - 100/7 -> after 9 edges valid_o=1, q_o=14, r_o=2.
// - -100/7 -> q_o=0xFFFFFFF2 (-14), r_o=0xFFFFFFFE (-2).
// - 100/-7 -> q_o=-14, r_o=2.
// - 5/0 -> q_o=0xFFFFFFFF, r_o=5.
// - 0x80000000/0xFFFFFFFF -> q_o=0x80000000, r_o=0.
// - 0x80000000/1 -> q_o=0x80000000, r_o=0.
// - Back-to-back 20/3, 21/3, 22/3, then pea_ready_i=0 for 4 cycles after the 2nd op, then resume:
//   - Expect exactly three valid_o pulses in order: (6,2), (7,0), (7,1).
//   - Outputs frozen during the stall; no loss or duplication.
// - Random 10k signed pairs with random in_valid_i/pea_ready_i gaps:
//   - q_o/r_o match the $signed / and % scoreboard model (special-case rules above).
//   - Output count equals input count.
// - Reset mid-flight: 4 ops in flight, assert rst_i 1 cycle:
//   - valid_o=0, q_o=r_o=0 next cycle.
//   - No stale result appears afterwards.
//   - A new 9/2 afterwards yields q=4, r=1 at latency 9.

Source files
------------

// File: rtl/div_radix_pipe_pkg.sv
// div_radix_pipe_pkg: widths, pipeline stage record and helpers for the pipelined divider
package div_radix_pipe_pkg;
  localparam int N_BITS = 32;
  localparam int DIV_STAGES = 8;
  localparam int BPS = N_BITS / DIV_STAGES;
  localparam logic [N_BITS-1:0] INT_MIN = {1'b1, {(N_BITS-1){1'b0}}};
  typedef struct packed {
    logic              valid;
    logic              dz;
    logic              ovf;
    logic              sign_q;
    logic              sign_r;
    logic [N_BITS-1:0] a_orig;
    logic [N_BITS-1:0] div_abs;
    logic [N_BITS-1:0] dvd_rem;
    logic [N_BITS:0]   p;
    logic [N_BITS-1:0] q;
  } div_stage_t;
  // |INT_MIN| wraps back to 0x80..0, which is exactly 2^(N_BITS-1) when read unsigned
  function automatic logic [N_BITS-1:0] abs_val(input logic [N_BITS-1:0] x);
    return x[N_BITS-1] ? -x : x;
  endfunction
endpackage

// File: rtl/div_radix_pipe_stage.sv
// div_radix_pipe_stage: combinational BPS-step restoring division slice
module div_radix_pipe_stage
  import div_radix_pipe_pkg::*;
(
  input  div_stage_t d,
  output div_stage_t o
);
  div_stage_t t;
  logic qb;
  always_comb begin
    t = d;
    qb = 1'b0;
    for (int i = 0; i < BPS; i++) begin
      t.p = {t.p[N_BITS-1:0], t.dvd_rem[N_BITS-1]};
      t.dvd_rem = t.dvd_rem << 1;
      qb = t.p >= {1'b0, t.div_abs};
      t.p = qb ? t.p - {1'b0, t.div_abs} : t.p;
      t.q = {t.q[N_BITS-2:0], qb};
    end
    o = t;
  end
endmodule

// File: rtl/div_radix_pipe.sv
// div_radix_pipe: pipelined signed divider, one op per advancing cycle, latency DIV_STAGES+1
module div_radix_pipe
  import div_radix_pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pea_ready_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              in_valid_i,
  output logic [N_BITS-1:0] q_o,
  output logic [N_BITS-1:0] r_o,
  output logic              valid_o
);
  div_stage_t c, t;
  div_stage_t s [DIV_STAGES];
  div_stage_t n [DIV_STAGES];
  logic [N_BITS-1:0] q_nxt, r_nxt;
  logic unused_bits;
  always_comb begin
    c = '0;
    c.valid = in_valid_i;
    c.dz = b_i == '0;
    c.ovf = a_i == INT_MIN && b_i == '1;
    c.sign_q = a_i[N_BITS-1] ^ b_i[N_BITS-1];
    c.sign_r = a_i[N_BITS-1];
    c.a_orig = a_i;
    c.div_abs = abs_val(b_i);
    c.dvd_rem = abs_val(a_i);
  end
  // slice 0 works on the conditioned inputs so stage-0 register already holds BPS quotient bits
  genvar k;
  for (k = 0; k < DIV_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      div_radix_pipe_stage u_stage (.d(c), .o(n[k]));
    end else begin : g_rest
      div_radix_pipe_stage u_stage (.d(s[k-1]), .o(n[k]));
    end
  end
  always_comb begin
    t = s[DIV_STAGES-1];
    q_nxt = t.dz ? '1 : t.ovf ? INT_MIN : t.sign_q ? -t.q : t.q;
    r_nxt = t.dz ? t.a_orig : t.ovf ? '0 : t.sign_r ? -t.p[N_BITS-1:0] : t.p[N_BITS-1:0];
  end
  assign unused_bits = ^{t.p[N_BITS], t.dvd_rem, t.div_abs};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s <= '{default: '0};
      valid_o <= 1'b0;
      q_o <= '0;
      r_o <= '0;
    end else if (pea_ready_i) begin
      for (int i = 0; i < DIV_STAGES; i++) s[i] <= n[i];
      valid_o <= t.valid;
      q_o <= t.valid ? q_nxt : q_o;
      r_o <= t.valid ? r_nxt : r_o;
    end
  end
endmodule

// File: tb/tb_div_radix_pipe.sv
// tb_div_radix_pipe: scoreboard bench with directed cases, stalls, reset flush and random traffic
module tb_div_radix_pipe;
  logic clk = 0, rst = 1, rdy = 1, vin = 0, vout;
  logic [31:0] a = 0, b = 0, q, r;
  logic [63:0] exp_q[$];
  int n_chk = 0, n_fail = 0, n_in = 0, n_out = 0;
  logic m_adv, m_rst, m_pv;
  logic [31:0] m_pq, m_pr;

  div_radix_pipe dut (.clk_i(clk), .rst_i(rst), .pea_ready_i(rdy), .a_i(a), .b_i(b),
                      .in_valid_i(vin), .q_o(q), .r_o(r), .valid_o(vout));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return {32'hFFFFFFFF, x};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
    return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic v, input logic rd);
    @(negedge clk);
    a = x; b = y; vin = v; rdy = rd;
    if (v && rd) begin
      exp_q.push_back(ref_div(x, y));
      n_in++;
    end
  endtask

  task automatic lat_check(input logic [31:0] x, input logic [31:0] y);
    int cnt;
    step(x, y, 1, 1);
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    vin = 0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      #1;
      if (vout) break;
    end
    chk("latency", 64'(cnt), 64'd9);
  endtask

  always @(posedge clk) begin
    m_adv = rdy; m_rst = rst; m_pv = vout; m_pq = q; m_pr = r;
    #1;
    if (m_rst) chk("reset_state", {31'b0, vout, q, r}, 65'b0);
    else if (!m_adv) chk("stall_hold", {31'b0, vout, q, r}, {31'b0, m_pv, m_pq, m_pr});
    else if (vout) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_output", {q, r}, 64'hX);
      else chk("result", {q, r}, exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    rst = 0;
    lat_check(100, 7);
    lat_check(32'(-100), 7);
    lat_check(100, 32'(-7));
    lat_check(5, 0);
    lat_check(32'h80000000, 32'hFFFFFFFF);
    lat_check(32'h80000000, 1);
    lat_check(0, 32'(-9));
    step(20, 3, 1, 1);
    step(21, 3, 1, 1);
    repeat (4) step(0, 0, 0, 0);
    step(22, 3, 1, 1);
    repeat (14) step(0, 0, 0, 1);
    chk("stall_drain", 64'(exp_q.size()), 64'd0);
    repeat (4) step($urandom, $urandom_range(1, 50), 1, 1);
    @(negedge clk);
    rst = 1; vin = 0;
    n_in -= exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (12) step(0, 0, 0, 1);
    lat_check(9, 2);
    for (int i = 0; i < 10000; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: y = 32'hFFFFFFFF;
        2: x = 32'h80000000;
        3: y = 32'($signed($urandom_range(0, 20)) - 10);
        4: x = 0;
        default: ;
      endcase
      step(x, y, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("io_count", 64'(n_out), 64'(n_in));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
